instruction_fetcher: RTL
========================

# instruction_fetcher

Fetch stage that sits directly upstream of the memory controller's fetch port and downstream of the ROB's redirect signal. It holds the PC and looks each instruction up in a direct-mapped instruction cache with one word per line. On a hit it issues the instruction to the instruction queue. On a miss it requests the word from the memory controller, refills the line, and retries. The predicted next PC is always pc+4; ROB redirects override it.

## Interface
- `ICACHE_IDX_WIDTH`, default 4: index bits; the cache has 2^4 = 16 lines.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `rdy_in`  in  1  pause; the block freezes while low.
- `jump_valid`  in  1  ROB redirect, one-cycle pulse.
- `jump_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- `mem_req`  out  1  fetch request to the memory controller; held high until `mem_done`.
- `mem_addr`  out  32  word-aligned fetch address; stable while `mem_req` is high.
- `mem_done`  in  1  one-cycle pulse meaning `mem_inst` is valid.
- `mem_inst`  in  32  fetched instruction word.
- `iq_full`  in  1  instruction queue cannot accept this cycle.
- `inst_valid`  out  1  one-cycle pulse: `inst_out` and `inst_pc` are valid.
- `inst_out`  out  32  instruction.
- `inst_pc`  out  32  address of `inst_out`.

## Operation
- Address fields:
  - index = `pc[ICACHE_IDX_WIDTH+1:2]`.
  - tag = `pc[31:ICACHE_IDX_WIDTH+2]`.
  - Each line stores a valid bit, a tag and a data word.
- States: IDLE and MISS. Reset enters IDLE.
- IDLE, hit, `!iq_full`:
  - register `inst_out`, `inst_pc` = pc and `inst_valid` = 1.
  - pc <= pc+4.
- IDLE, hit, `iq_full`: hold pc; `inst_valid` = 0.
- IDLE, miss:
  - state <= MISS.
  - `mem_req` <= 1, `mem_addr` <= pc.
  - A miss is taken regardless of `iq_full`.
- MISS, `mem_done`:
  - write valid, tag and data at the index of `mem_addr`.
  - `mem_req` <= 0; state <= IDLE.
  - Nothing is issued this cycle. The next IDLE cycle hits.
- `jump_valid` has the highest priority in any state:
  - pc <= {`jump_pc[31:2]`, 2'b00}.
  - `inst_valid` <= 0; any same-cycle hit issue is suppressed.
- `jump_valid` in MISS:
  - The outstanding request is not aborted; `mem_req` and `mem_addr` are held.
  - On `mem_done` the line is still filled for `mem_addr` (the data is correct for that address), then the block returns to IDLE and looks up the new pc.
  - No stale instruction is ever emitted.
- `jump_valid` in the same cycle as `mem_done`: perform both the fill and the pc update.
- `rdy_in` low: no register changes except `inst_valid` <= 0. `mem_req` and `mem_addr` hold.
- Cache contents are never invalidated except by reset; there is no self-modifying-code support.
- pc arithmetic wraps modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000.

## Timing
- Reset values:
  - pc = 0x00000000, state = IDLE.
  - `mem_req` = 0, `mem_addr` = 0.
  - `inst_valid` = 0, `inst_out` = 0, `inst_pc` = 0.
  - All cache valid bits = 0.
- Reset asserted mid-miss: the request is dropped immediately. The memory controller is reset by the same signal.
- Hit latency: lookup in cycle N gives `inst_valid` high in cycle N+1. Back-to-back hits give 1 instruction per cycle.
- Miss:
  - `mem_req` rises in cycle N+1.
  - `mem_done` arrives in cycle M; the fill is written at the end of M.
  - The lookup hits in M+1, so `inst_valid` is high in M+2.
- After `jump_valid` in cycle J, the first possible `inst_valid` carrying the target is in cycle J+2.
- `iq_full` is sampled in the lookup cycle. `inst_valid` is never asserted in the cycle after `iq_full` was high.

## Structure
- Shared constants file (`operaType.v`): `TRUE`/`FALSE`, fetch state encodings `FETCH_IDLE`/`FETCH_MISS`.
- Sub-module `icache_array`:
  - valid, tag and data arrays.
  - Combinational read (hit, data) from an index and tag.
  - Synchronous write port.
  - Asynchronous clear of the valid bits on `rst_in`.

## Test plan
- **Reset:** assert `rst_in` mid-run → all outputs 0 and pc 0. The first lookup at 0x0 misses and `mem_req` goes high with `mem_addr` = 0x0.
- **Cold miss then hit:** `mem_done` with `mem_inst` = 0x00000013 three cycles after `mem_req` → two cycles later, `inst_valid` with `inst_out` = 0x13 and `inst_pc` = 0x0. `mem_req` rises next for 0x4.
- **Warm loop:** pre-fill 0x0–0xC, then jump to 0x0 → four consecutive `inst_valid` pulses with pcs 0x0, 0x4, 0x8, 0xC.
- **Stall:** hold `iq_full` for 3 cycles during hits → no `inst_valid` and pc held. After release, the same pc is issued next.
- **Jump during miss:** miss at 0x8, `jump_valid` to 0x40 before `mem_done` → line 2 is filled for 0x8 and 0x8 is never issued. 0x40 misses; it aliases line 0, whose tag differs from 0x0. `mem_addr` = 0x40.
- **Pause:** `rdy_in` low for 5 cycles in MISS with `mem_done` absent → `mem_req` and `mem_addr` are stable and no `inst_valid`. Operation resumes correctly when `rdy_in` returns high.

Source files
------------

// File: rtl/instruction_fetcher_pkg.sv
// Shared fetch-stage definitions: truth constants, fetch FSM encoding and the
// issued-instruction payload.
package instruction_fetcher_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_MISS = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } fetch_pkt_t;

   // Clears the byte offset so every fetch address is word aligned.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/instruction_fetcher_icache_array.sv
// Direct-mapped, one-word-per-line instruction cache storage: combinational
// lookup, synchronous fill, valid bits cleared asynchronously by reset.
module instruction_fetcher_icache_array
   import instruction_fetcher_pkg::*;
#(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned TAG_W = 26
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             hit_c,
   output logic [XLEN-1:0]  rd_data_c,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [XLEN-1:0]  wr_data
);

   localparam int unsigned LINES = 1 << IDX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [XLEN-1:0]  data_q [LINES];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= TRUE;
      end
   end

   // Tag and data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign hit_c     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_data_c = data_q[rd_idx];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: holds the PC, looks it up in the icache, issues hits to the
// instruction queue and refills misses from the memory controller.
module instruction_fetcher
   import instruction_fetcher_pkg::*;
#(
   parameter int unsigned ICACHE_IDX_WIDTH = 4
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_done,
   input  logic [XLEN-1:0] mem_inst,
   input  logic            iq_full,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_out,
   output logic [XLEN-1:0] inst_pc
);

   localparam int unsigned IDX_LO = 2;
   localparam int unsigned TAG_LO = ICACHE_IDX_WIDTH + 2;
   localparam int unsigned TAG_W  = XLEN - TAG_LO;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            mem_req_d;
   logic [XLEN-1:0] mem_addr_d;
   logic            inst_valid_d;
   fetch_pkt_t      issue_q, issue_d;

   logic            hit_c;
   logic [XLEN-1:0] rd_data_c;
   logic            fill_en_c;

   instruction_fetcher_icache_array #(
      .IDX_W (ICACHE_IDX_WIDTH),
      .TAG_W (TAG_W)
   ) u_icache_array (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rd_idx    (pc_q[TAG_LO-1:IDX_LO]),
      .rd_tag    (pc_q[XLEN-1:TAG_LO]),
      .hit_c     (hit_c),
      .rd_data_c (rd_data_c),
      .wr_en     (fill_en_c),
      .wr_idx    (mem_addr[TAG_LO-1:IDX_LO]),
      .wr_tag    (mem_addr[XLEN-1:TAG_LO]),
      .wr_data   (mem_inst)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= '0;
         mem_req    <= FALSE;
         mem_addr   <= '0;
         inst_valid <= FALSE;
         issue_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req    <= mem_req_d;
         mem_addr   <= mem_addr_d;
         inst_valid <= inst_valid_d;
         issue_q    <= issue_d;
      end
   end

   // A redirect wins over any lookup result; an outstanding refill is never
   // aborted, so its line is still written when the data returns.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      mem_req_d    = mem_req;
      mem_addr_d   = mem_addr;
      inst_valid_d = FALSE;
      issue_d      = issue_q;
      fill_en_c    = FALSE;

      if (rdy_in) begin
         case (state_q)
            FETCH_IDLE: begin
               if (!jump_valid && !hit_c) begin
                  state_d    = FETCH_MISS;
                  mem_req_d  = TRUE;
                  mem_addr_d = pc_q;
               end else if (!jump_valid && !iq_full) begin
                  inst_valid_d = TRUE;
                  issue_d.inst = rd_data_c;
                  issue_d.pc   = pc_q;
                  pc_d         = pc_q + XLEN'(4);
               end
            end
            FETCH_MISS: begin
               if (mem_done) begin
                  fill_en_c = TRUE;
                  mem_req_d = FALSE;
                  state_d   = FETCH_IDLE;
               end
            end
            default: state_d = FETCH_IDLE;
         endcase

         if (jump_valid) begin
            pc_d = word_align(jump_pc);
         end
      end
   end

   assign inst_out = issue_q.inst;
   assign inst_pc  = issue_q.pc;

endmodule
